zynet_frame_sequencer: RTL and testbench
========================================

ZYNET_FRAME_SEQUENCER -- requirements
Module: zynet_frame_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 16, bit width of one sample and of one result word.
REQ-002 Parameter OUTPUT_SIZE, default 10, number of result words in the CNN output vector.
REQ-003 Parameter FRAME_LEN, default 64, number of input samples per frame; SHALL be at least 2.
REQ-004 Port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start_i, input, 1 bit: host request to process one frame.
REQ-007 Port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-008 Port done_o, output, 1 bit: one-cycle pulse when the last result word is accepted.
REQ-009 Ports data_i (input, WORD_SIZE), valid_i (input, 1), ready_o (output, 1): host sample stream.
REQ-010 Ports cnn_start_o (output, 1) and cnn_conv_ready_i (input, 1): CNN start and convolution-ready.
REQ-011 Ports cnn_data_o (output, WORD_SIZE), cnn_valid_o (output, 1), cnn_ready_i (input, 1): CNN sample input.
REQ-012 Ports cnn_data_i (input, OUTPUT_SIZE*WORD_SIZE), cnn_valid_i (input, 1), cnn_yumi_o (output, 1): CNN result vector.
REQ-013 Ports data_o (output, WORD_SIZE), index_o (output, clog2(OUTPUT_SIZE)), valid_o (output, 1), yumi_i (input, 1): serialized result stream.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT_RDY, STREAM, WAIT_RES and DRAIN.
REQ-015 IDLE: if start_i=1, go to START; start_i SHALL be ignored in every other state.
REQ-016 START: cnn_start_o=1 for exactly this one cycle, then go to WAIT_RDY.
REQ-017 WAIT_RDY: hold until cnn_conv_ready_i=1, then go to STREAM on the next cycle.
REQ-018 STREAM datapath (combinational pass-through): cnn_data_o=data_i, cnn_valid_o=valid_i, ready_o=cnn_ready_i.
REQ-019 STREAM counting: a sample counter increments on each valid_i&&cnn_ready_i; on the FRAME_LEN-th handshake, go to WAIT_RES.
REQ-020 Outside STREAM, ready_o=0 and cnn_valid_o=0; host samples are held off and never dropped.
REQ-021 WAIT_RES: when cnn_valid_i=1, register cnn_data_i, assert cnn_yumi_o=1 in that same cycle, clear the word index, go to DRAIN.
REQ-022 cnn_yumi_o SHALL be 0 in every other state and cycle.
REQ-023 DRAIN outputs: valid_o=1; data_o=captured bits [WORD_SIZE*(k+1)-1 : WORD_SIZE*k] with k=index_o (word 0 in the LSBs).
REQ-024 DRAIN handshake: yumi_i=1 advances index_o; yumi_i while valid_o=0 SHALL have no effect.
REQ-025 DRAIN exit: yumi_i at index OUTPUT_SIZE-1 asserts done_o for that cycle and returns to IDLE.
REQ-026 Back-to-back frames: start_i in the cycle after done_o SHALL enter START with no extra bubble.
REQ-027 The captured vector SHALL remain stable throughout DRAIN, whatever cnn_data_i does.
REQ-028 A stall on either stream (valid_i=0, cnn_ready_i=0, yumi_i=0) SHALL hold all counters and state indefinitely.

Reset
REQ-029 On reset_i=1: state=IDLE, counters=0, and busy_o, done_o, ready_o, valid_o, cnn_start_o, cnn_valid_o, cnn_yumi_o=0.
REQ-030 data_o and index_o SHALL read 0 after reset.
REQ-031 Reset mid-frame SHALL abandon the frame with no done_o pulse; the CNN shares reset_i and is cleared with it.

Structure
REQ-032 A package zynet_pkg SHALL hold the state enum and the default WORD_SIZE, OUTPUT_SIZE and FRAME_LEN constants.
REQ-033 Result capture and word selection SHALL be a sub-module zynet_result_serializer (load, yumi_i, data_o, index_o, last).
REQ-034 The FSM and sample counter SHALL live in the top module; total RTL is 120-400 lines.

Verification
REQ-035 Full frame: start_i pulse, samples 1..64 with no stalls, CNN returns words 0x0010..0x0019 -> cnn_start_o is a single one-cycle pulse; exactly 64 CNN handshakes; data_o reads 0x0010..0x0019 with index_o 0..9; done_o pulses once.
REQ-036 Stalls: random valid_i, cnn_ready_i and yumi_i gaps -> CNN receives 64 samples in order with no loss or duplication, and results are unchanged.
REQ-037 Ignored start: start_i held high in STREAM and DRAIN -> no second cnn_start_o until IDLE; a 65th host sample sees ready_o=0.
REQ-038 Reset mid-frame: reset_i asserted at sample 30 -> next cycle busy_o=0, ready_o=0, no done_o; a following full frame completes correctly.
REQ-039 Back-to-back: start_i in the done_o+1 cycle -> cnn_start_o one cycle later; the second frame's results come out intact.
REQ-040 Result hold: cnn_data_i changes during DRAIN -> data_o still shows the captured words.

Source files
------------

// File: rtl/zynet_pkg.sv
// Shared definitions for the ZyNet frame sequencer.
// Holds the sequencer state encoding, the default geometry constants and a
// helper that sizes index fields safely for degenerate (size 1) cases.
package zynet_pkg;

    localparam int WORD_SIZE_DEF   = 16;
    localparam int OUTPUT_SIZE_DEF = 10;
    localparam int FRAME_LEN_DEF   = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_RDY,
        STREAM,
        WAIT_RES,
        DRAIN
    } state_t;

    // Width of an index over n items; never zero so ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zynet_result_serializer.sv
// Captures the CNN result vector and presents it one word at a time.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : capture vec_i and restart at word 0
//   vec_i          : packed result vector, word 0 in the LSBs
//   yumi_i         : current word consumed, advance to the next one
//   data_o         : currently selected word
//   index_o        : index of the currently selected word
//   last_o         : the selected word is the final one
module zynet_result_serializer
    import zynet_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int OUTPUT_SIZE = OUTPUT_SIZE_DEF,
    parameter int IDX_W       = idx_width(OUTPUT_SIZE)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             load_i,
    input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] vec_i,
    input  logic                             yumi_i,
    output logic [WORD_SIZE-1:0]             data_o,
    output logic [IDX_W-1:0]                 index_o,
    output logic                             last_o
);

    logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] words_q;
    logic [IDX_W-1:0]                      idx_q;

    // The capture register only changes on load, so the words stay stable
    // for the whole drain no matter what the CNN drives afterwards.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            words_q <= '0;
            idx_q   <= '0;
        end else if (load_i) begin
            words_q <= vec_i;
            idx_q   <= '0;
        end else if (yumi_i) begin
            // Wrap to 0 after the last word so the index idles at zero.
            idx_q <= last_o ? '0 : idx_q + 1'b1;
        end
    end

    assign last_o  = (idx_q == IDX_W'(OUTPUT_SIZE - 1));
    assign data_o  = words_q[idx_q];
    assign index_o = idx_q;

endmodule

// File: rtl/zynet_frame_sequencer.sv
// Sequences one frame through a CNN: pulses the CNN start, waits for the
// convolution engine, streams FRAME_LEN host samples into it, captures the
// result vector and serializes it back to the host word by word.
// Ports:
//   clk_i, reset_i                       : clock, synchronous active-high reset
//   start_i, busy_o, done_o              : host control / status
//   data_i, valid_i, ready_o             : host sample stream in
//   cnn_start_o, cnn_conv_ready_i        : CNN start / convolution ready
//   cnn_data_o, cnn_valid_o, cnn_ready_i : CNN sample stream out
//   cnn_data_i, cnn_valid_i, cnn_yumi_o  : CNN result vector in
//   data_o, index_o, valid_o, yumi_i     : serialized result stream out
module zynet_frame_sequencer
    import zynet_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int OUTPUT_SIZE = OUTPUT_SIZE_DEF,
    parameter int FRAME_LEN   = FRAME_LEN_DEF
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    output logic                               busy_o,
    output logic                               done_o,
    input  logic [WORD_SIZE-1:0]               data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic                               cnn_start_o,
    input  logic                               cnn_conv_ready_i,
    output logic [WORD_SIZE-1:0]               cnn_data_o,
    output logic                               cnn_valid_o,
    input  logic                               cnn_ready_i,
    input  logic [OUTPUT_SIZE*WORD_SIZE-1:0]   cnn_data_i,
    input  logic                               cnn_valid_i,
    output logic                               cnn_yumi_o,
    output logic [WORD_SIZE-1:0]               data_o,
    output logic [idx_width(OUTPUT_SIZE)-1:0]  index_o,
    output logic                               valid_o,
    input  logic                               yumi_i
);

    localparam int CNT_W = idx_width(FRAME_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             sample_hs;
    logic             sample_last;
    logic             res_last;
    logic             res_yumi;

    assign sample_hs   = (state_q == STREAM) && valid_i && cnn_ready_i;
    assign sample_last = (cnt_q == CNT_W'(FRAME_LEN - 1));
    // Host yumi only counts while a word is actually being offered.
    assign res_yumi    = (state_q == DRAIN) && yumi_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (sample_hs)
                cnt_q <= sample_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnn_start_o = 1'b0;
        cnn_valid_o = 1'b0;
        ready_o     = 1'b0;
        cnn_yumi_o  = 1'b0;
        valid_o     = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i)
                    state_d = START;
            end
            START: begin
                cnn_start_o = 1'b1;
                state_d     = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (cnn_conv_ready_i)
                    state_d = STREAM;
            end
            STREAM: begin
                cnn_valid_o = valid_i;
                ready_o     = cnn_ready_i;
                if (sample_hs && sample_last)
                    state_d = WAIT_RES;
            end
            WAIT_RES: begin
                // Capture and acknowledge the vector in the same cycle.
                cnn_yumi_o = cnn_valid_i;
                if (cnn_valid_i)
                    state_d = DRAIN;
            end
            DRAIN: begin
                valid_o = 1'b1;
                if (yumi_i && res_last) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign cnn_data_o = data_i;

    zynet_result_serializer #(
        .WORD_SIZE   (WORD_SIZE),
        .OUTPUT_SIZE (OUTPUT_SIZE)
    ) u_ser (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (cnn_yumi_o),
        .vec_i   (cnn_data_i),
        .yumi_i  (res_yumi),
        .data_o  (data_o),
        .index_o (index_o),
        .last_o  (res_last)
    );

endmodule

// File: tb/tb_zynet_frame_sequencer.sv
module tb_zynet_frame_sequencer;
    localparam int W  = 16;
    localparam int O  = 10;
    localparam int F  = 64;
    localparam int IW = 4;

    logic             clk_i = 1'b0;
    logic             reset_i, start_i, busy_o, done_o;
    logic [W-1:0]     data_i;
    logic             valid_i, ready_o;
    logic             cnn_start_o, cnn_conv_ready_i;
    logic [W-1:0]     cnn_data_o;
    logic             cnn_valid_o, cnn_ready_i;
    logic [O*W-1:0]   cnn_data_i;
    logic             cnn_valid_i, cnn_yumi_o;
    logic [W-1:0]     data_o;
    logic [IW-1:0]    index_o;
    logic             valid_o, yumi_i;

    zynet_frame_sequencer #(.WORD_SIZE(W), .OUTPUT_SIZE(O), .FRAME_LEN(F)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o),
        .done_o(done_o), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .cnn_start_o(cnn_start_o), .cnn_conv_ready_i(cnn_conv_ready_i),
        .cnn_data_o(cnn_data_o), .cnn_valid_o(cnn_valid_o), .cnn_ready_i(cnn_ready_i),
        .cnn_data_i(cnn_data_i), .cnn_valid_i(cnn_valid_i), .cnn_yumi_o(cnn_yumi_o),
        .data_o(data_o), .index_o(index_o), .valid_o(valid_o), .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame progress expressed as event counts and flags.
    bit m_idle = 1, m_start = 0, m_waitrdy = 0, m_stream = 0, m_have = 0;
    int m_samples = 0, m_words = 0;
    logic [W-1:0] m_vec [O];

    // Scoreboard / bookkeeping
    int frame_base = 0;
    logic [W-1:0] frame_vec [O];
    logic [W-1:0] rec_samp [$];
    logic [W-1:0] rec_words [$];
    int  start_total = 0, done_total = 0, cyc = 0, done_cyc = 0, start_cyc = 0;
    bit  cnn_yumied = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_waitres();
        return !m_idle && !m_start && !m_waitrdy && !m_stream && !m_have;
    endfunction

    // One clock: compare at negedge, advance the model for the coming edge.
    task automatic step();
        bit hs, wr;
        @(negedge clk_i);
        cyc++;
        wr = m_waitres();
        hs = m_stream && valid_i && cnn_ready_i;
        chk("busy_o",      64'(busy_o),      64'(!m_idle));
        chk("cnn_start_o", 64'(cnn_start_o), 64'(m_start));
        chk("ready_o",     64'(ready_o),     64'(m_stream && cnn_ready_i));
        chk("cnn_valid_o", 64'(cnn_valid_o), 64'(m_stream && valid_i));
        chk("cnn_yumi_o",  64'(cnn_yumi_o),  64'(wr && cnn_valid_i));
        chk("valid_o",     64'(valid_o),     64'(m_have));
        chk("done_o",      64'(done_o),      64'(m_have && yumi_i && m_words == O - 1));
        if (hs) begin
            chk("cnn_data_o", 64'(cnn_data_o), 64'(W'(frame_base + m_samples + 1)));
            rec_samp.push_back(cnn_data_o);
        end
        if (m_have) begin
            chk("data_o",  64'(data_o),  64'(m_vec[m_words]));
            chk("index_o", 64'(index_o), 64'(m_words));
            if (yumi_i) begin
                chk("result_word", 64'(data_o), 64'(frame_vec[m_words]));
                rec_words.push_back(data_o);
            end
        end
        if (cnn_start_o) begin start_total++; start_cyc = cyc; end
        if (done_o) begin done_total++; done_cyc = cyc; end

        if (reset_i) begin
            m_idle = 1; m_start = 0; m_waitrdy = 0; m_stream = 0; m_have = 0;
            m_samples = 0; m_words = 0; cnn_yumied = 0;
        end else if (m_idle) begin
            if (start_i) begin m_idle = 0; m_start = 1; end
        end else if (m_start) begin
            m_start = 0; m_waitrdy = 1;
        end else if (m_waitrdy) begin
            if (cnn_conv_ready_i) begin m_waitrdy = 0; m_stream = 1; end
        end else if (m_stream) begin
            if (hs) begin
                m_samples++;
                if (m_samples == F) m_stream = 0;
            end
        end else if (wr) begin
            if (cnn_valid_i) begin
                for (int i = 0; i < O; i++) m_vec[i] = cnn_data_i[i*W +: W];
                m_have = 1; m_words = 0; cnn_yumied = 1;
            end
        end else if (m_have && yumi_i) begin
            m_words++;
            if (m_words == O) begin
                m_have = 0; m_idle = 1; m_samples = 0; m_words = 0; cnn_yumied = 0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit rnd(input bit stall);
        return !stall || ($urandom_range(0, 2) != 0);
    endfunction

    task automatic drive(input bit first, input bit stall, input bit hold);
        start_i          = first || (hold && !m_idle);
        valid_i          = (m_samples < F || hold) && rnd(stall);
        data_i           = W'(frame_base + m_samples + 1);
        cnn_ready_i      = rnd(stall);
        cnn_conv_ready_i = rnd(stall);
        yumi_i           = rnd(stall);
        cnn_valid_i      = rnd(stall);
        for (int i = 0; i < O; i++)
            cnn_data_i[i*W +: W] = (m_samples == F && !cnn_yumied) ? frame_vec[i] : W'($urandom);
    endtask

    // Runs one frame; returns 1 if it reached done_o.
    task automatic run_frame(input int base, input bit lit_vec, input bit stall,
                             input bit hold, input int reset_at, output bit ok);
        int d0, s0;
        bit first;
        frame_base = base;
        for (int i = 0; i < O; i++) frame_vec[i] = lit_vec ? W'(16'h0010 + i) : W'($urandom);
        rec_samp.delete();
        rec_words.delete();
        d0 = done_total; s0 = start_total; first = 1; ok = 0;
        for (int c = 0; c < 3000; c++) begin
            drive(first, stall, hold);
            first = 0;
            if (reset_at >= 0 && m_stream && m_samples == reset_at) begin
                reset_i = 1;
                step();
                reset_i = 0;
                chk("no_done_after_reset", 64'(done_total), 64'(d0));
                return;
            end
            step();
            if (done_total != d0) begin ok = 1; break; end
        end
        chk("frame_completed", 64'(ok), 64'(1));
        chk("start_pulses",    64'(start_total - s0), 64'(1));
        chk("done_pulses",     64'(done_total - d0),  64'(1));
        chk("cnn_handshakes",  64'(rec_samp.size()),  64'(F));
        for (int i = 0; i < rec_samp.size(); i++)
            if (rec_samp[i] !== W'(base + i + 1)) chk("sample_order", 64'(rec_samp[i]), 64'(W'(base + i + 1)));
    endtask

    initial begin
        bit ok;
        int dc;
        reset_i = 1; start_i = 0; valid_i = 0; data_i = '0; cnn_ready_i = 0;
        cnn_conv_ready_i = 0; cnn_valid_i = 0; cnn_data_i = '0; yumi_i = 0;
        repeat (3) step();
        reset_i = 0;
        chk("reset_data_o",  64'(data_o),  64'(0));
        chk("reset_index_o", 64'(index_o), 64'(0));
        chk("reset_busy_o",  64'(busy_o),  64'(0));

        // Clean frame with literal results 0x0010..0x0019
        run_frame(0, 1, 0, 0, -1, ok);
        chk("lit_words_n", 64'(rec_words.size()), 64'(O));
        for (int i = 0; i < rec_words.size(); i++)
            chk("lit_word", 64'(rec_words[i]), 64'(16'h0010 + i));
        chk("lit_first_sample", 64'(rec_samp[0]),     64'(1));
        chk("lit_last_sample",  64'(rec_samp[F - 1]), 64'(64));

        // Randomly stalled frames
        for (int f = 0; f < 3; f++) run_frame(100 * (f + 1), 0, 1, 0, -1, ok);

        // start_i held high throughout, extra host sample offered
        run_frame(500, 0, 0, 1, -1, ok);
        run_frame(600, 0, 1, 1, -1, ok);

        // Reset mid-frame at sample 30, then a full frame
        run_frame(700, 0, 0, 0, 30, ok);
        chk("reset_abort_busy", 64'(busy_o), 64'(0));
        run_frame(800, 1, 1, 0, -1, ok);

        // Back-to-back frames
        run_frame(900, 0, 0, 0, -1, ok);
        dc = done_cyc;
        run_frame(1000, 1, 0, 0, -1, ok);
        chk("b2b_start_latency", 64'(start_cyc - dc), 64'(2));
        for (int i = 0; i < rec_words.size(); i++)
            chk("b2b_word", 64'(rec_words[i]), 64'(16'h0010 + i));

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
